sram_bank_array: RTL
====================

# sram_bank_array

Multi-port, multi-bank on-chip scratchpad SRAM with real storage, per-bank round-robin arbitration, byte-enable writes, and a fixed one-cycle read latency. NUM_PORTS requestors (DMA, PE-array feeders, host) share NUM_BANKS single-ported banks. Each bank serves at most one access per cycle. The block sits between the NPU datapath clients and the physical scratchpad, and it is the functional successor of the single-cycle pass-through bank stub.

## Interface
- NUM_PORTS, 2: number of requestor ports (1..8)
- NUM_BANKS, 4: number of banks, power of two (1..16)
- ADDR_WIDTH, 10: word address width per bank; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32: word width, multiple of 8
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_we  in  NUM_PORTS  1 = write, 0 = read
- req_bank  in  NUM_PORTS*BW  bank select, BW = max(1,$clog2(NUM_BANKS)), port p at [p*BW +: BW]
- req_addr  in  NUM_PORTS*ADDR_WIDTH  word address within bank
- req_wdata  in  NUM_PORTS*DATA_WIDTH  write data
- req_be  in  NUM_PORTS*DATA_WIDTH/8  byte enables, writes only
- req_ready  out  NUM_PORTS  request accepted this cycle (combinational grant)
- resp_valid  out  NUM_PORTS  read data valid
- resp_rdata  out  NUM_PORTS*DATA_WIDTH  read data
- conflict_cnt  out  32  saturating count of cycles with at least one stalled valid request

## Operation
- A port's request transfers when req_valid && req_ready in the same cycle. The port holds all req_* fields stable until it is accepted.
- Per bank, the arbiter collects the ports whose valid request targets that bank and grants exactly one, round-robin. The priority pointer starts at port 0.
- After a grant to port g, that bank's pointer moves to g+1 mod NUM_PORTS. With no grant, the pointer is unchanged.
- req_ready[p] depends only on req_valid and req_bank. It does not depend on req_we, addr or data.
- An accepted write updates only the bytes with req_be set. be = 0 is legal; it is a no-op that is still accepted. Writes produce no response.
- An accepted read returns the word addressed, as stored before this cycle's edge, with resp_valid[p]=1 one cycle later.
- Different ports hitting different banks in the same cycle all proceed in parallel.
- The responding port is tracked per bank. resp_rdata[p] is driven from the bank that port p read. Otherwise resp_rdata[p] holds its previous value.
- conflict_cnt increments when any port has req_valid && !req_ready. It saturates at 0xFFFF_FFFF.
- Storage contents are not reset. Reading an unwritten location returns X in simulation; the bench must not check such reads.

## Timing
- Reset values: resp_valid = 0, resp_rdata = 0, conflict_cnt = 0, all arbiter pointers = 0. req_ready is combinational and is 0 whenever req_valid = 0.
- Read latency is exactly 1 cycle, with no response backpressure. Clients must sink a response in the cycle it is presented.
- Throughput is one access per bank per cycle. A port can issue back-to-back accepted requests every cycle.
- Read followed by write to the same address in consecutive cycles: the read returns the old data.
- Write then read in consecutive cycles: the read returns the new data.
- Reset asserted mid-operation: in-flight reads are dropped, resp_valid goes to 0 immediately (async), and pointers return to 0. Memory contents are undefined after reset.
- Out-of-range req_bank (NUM_BANKS not a power of two) cannot occur, because NUM_BANKS is constrained to powers of two.

## Structure
- Shared package npu_sram_pkg holds the following:
  - the BW function
  - the byte-lane count constant
  - the rr_ptr_t typedef
  - the conflict counter width
- Sub-module bank_rr_arbiter (NUM_PORTS-wide request vector → one-hot grant, registered pointer) is instantiated once per bank. Storage is one inferred reg array per bank inside a generate loop.

## Test plan
- Single port, write 0xDEADBEEF to bank 2 addr 0x3F, be=4'hF, then read it back → resp_valid one cycle after acceptance, rdata 0xDEADBEEF.
- Byte-enable merge: write 0x11223344, then write 0xAABBCCDD with be=4'b0101, then read → 0x11BB33DD.
- Both ports read bank 1 continuously for 4 cycles → grants alternate 0,1,0,1, each port sees 2 responses, and conflict_cnt = 4.
- Port 0 on bank 0 and port 1 on bank 3 in the same cycle → both req_ready = 1, both responses the next cycle, conflict_cnt unchanged.
- Read and write to the same address in consecutive cycles, in both orders → old data and new data respectively.
- Assert rst while a read is in flight → resp_valid = 0 the next cycle, conflict_cnt = 0, and the first post-reset conflict grants port 0.

Source files
------------

// File: rtl/npu_sram_pkg.sv
// rtl/npu_sram_pkg.sv - shared constants, types and helpers for the scratchpad SRAM
//
// Purpose: common definitions used by sram_bank_array and bank_rr_arbiter.
// Ports: none (package).
package npu_sram_pkg;

  // Bits per byte lane; byte enables cover DATA_WIDTH/BYTE_W lanes.
  localparam int BYTE_W = 8;

  // Width of the stall/conflict counter.
  localparam int CNT_W = 32;

  // Round-robin pointer wide enough for up to 8 ports.
  localparam int PTR_W = 3;
  typedef logic [PTR_W-1:0] rr_ptr_t;

  // Bank-select width; a single bank still uses one select bit.
  function automatic int bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of byte lanes in a data word.
  function automatic int byte_lanes(input int dw);
    return dw / BYTE_W;
  endfunction

endpackage

// File: rtl/sram_bank_array_arbiter.sv
// rtl/sram_bank_array_arbiter.sv - per-bank round-robin arbiter with registered pointer
//
// Purpose: picks one requesting port per cycle, starting the search at the
//          priority pointer; the pointer moves past the winner on a grant.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   req_i     per-port request vector for this bank
//   gnt_o     one-hot grant (all zero when nobody requests)
module bank_rr_arbiter
  import npu_sram_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  rr_ptr_t ptr_q, ptr_d;
  rr_ptr_t win;
  logic    any;
  int      idx;

  // Scan ports starting at the pointer, wrapping once around.
  always_comb begin
    gnt_o = '0;
    win   = ptr_q;
    any   = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!any && req_i[idx]) begin
        any        = 1'b1;
        gnt_o[idx] = 1'b1;
        win        = rr_ptr_t'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any) ptr_d = (int'(win) == NUM_PORTS - 1) ? '0 : win + rr_ptr_t'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_bank_array.sv
// rtl/sram_bank_array.sv - multi-port, multi-bank scratchpad SRAM with round-robin banks
//
// Purpose: NUM_PORTS requestors share NUM_BANKS single-ported banks; each bank
//          grants one port per cycle, writes honour byte enables, reads
//          return one cycle after acceptance.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   req_valid/we    per-port request valid and write select
//   req_bank/addr   per-port bank select and word address
//   req_wdata/be    per-port write data and byte enables
//   req_ready       per-port combinational grant
//   resp_valid      per-port read data valid
//   resp_rdata      per-port read data (holds last value when idle)
//   conflict_cnt    saturating count of cycles with any stalled request
module sram_bank_array
  import npu_sram_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_PORTS-1:0]                           req_valid,
  input  logic [NUM_PORTS-1:0]                           req_we,
  input  logic [NUM_PORTS*bw(NUM_BANKS)-1:0]             req_bank,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]                req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]                req_wdata,
  input  logic [NUM_PORTS*byte_lanes(DATA_WIDTH)-1:0]    req_be,
  output logic [NUM_PORTS-1:0]                           req_ready,
  output logic [NUM_PORTS-1:0]                           resp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]                resp_rdata,
  output logic [CNT_W-1:0]                               conflict_cnt
);

  localparam int BW = bw(NUM_BANKS);
  localparam int NB = byte_lanes(DATA_WIDTH);

  logic [NUM_PORTS-1:0]  bank_gnt   [NUM_BANKS];
  logic                  bank_rvld  [NUM_BANKS];
  rr_ptr_t               bank_rport [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  logic [NUM_PORTS*DATA_WIDTH-1:0] hold_q;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [NUM_PORTS-1:0]  req_vec, gnt;
    rr_ptr_t               sel;
    logic                  hit, we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvld_q;
    rr_ptr_t               rport_q;

    always_comb begin
      req_vec = '0;
      for (int p = 0; p < NUM_PORTS; p++)
        req_vec[p] = req_valid[p] && (req_bank[p*BW +: BW] == BW'(b));
    end

    bank_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (req_vec),
      .gnt_o (gnt)
    );

    // Steer the granted port's request fields onto the bank.
    always_comb begin
      sel = '0;
      for (int p = 0; p < NUM_PORTS; p++)
        if (gnt[p]) sel = rr_ptr_t'(p);
    end

    assign hit   = |gnt;
    assign we    = req_we[int'(sel)];
    assign addr  = req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata = req_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign be    = req_be[int'(sel)*NB +: NB];

    // Storage is never reset; synchronous read keeps it a plain RAM.
    always_ff @(posedge clk) begin
      if (hit && we) begin
        for (int l = 0; l < NB; l++)
          if (be[l]) mem[addr][l*BYTE_W +: BYTE_W] <= wdata[l*BYTE_W +: BYTE_W];
      end
      if (hit && !we) rdata_q <= mem[addr];
    end

    // Remember who is owed a response from this bank.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rvld_q  <= 1'b0;
        rport_q <= '0;
      end else begin
        rvld_q  <= hit && !we;
        rport_q <= sel;
      end
    end

    assign bank_gnt[b]   = gnt;
    assign bank_rvld[b]  = rvld_q;
    assign bank_rport[b] = rport_q;
    assign bank_rdata[b] = rdata_q;
  end

  // Route bank responses back to ports; idle ports keep their last word.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_rdata = hold_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      req_ready = req_ready | bank_gnt[b];
      if (bank_rvld[b]) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (bank_rport[b] == rr_ptr_t'(p)) begin
            resp_valid[p]                        = 1'b1;
            resp_rdata[p*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[b];
          end
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (|(req_valid & ~req_ready) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else begin
      hold_q <= resp_rdata;
      cnt_q  <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;

endmodule
